// File: rtl/fetch_unit_if.sv
// Instruction-fetch bus bundle: memory request/response, branch redirect and
// decode handoff. master = fetch unit side, slave = memory/execute/decode side.
interface fetch_unit_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        branch_en;
    logic [31:0] branch_target;
    logic        dec_valid;
    logic        dec_ready;
    logic [31:0] dec_instr;
    logic [31:0] dec_pc;
    logic [31:0] dec_pcplus8;

    modport master (
        output imem_req, imem_addr, dec_valid, dec_instr, dec_pc, dec_pcplus8,
        input  imem_ready, imem_rvalid, imem_rdata, branch_en, branch_target, dec_ready
    );

    modport slave (
        input  imem_req, imem_addr, dec_valid, dec_instr, dec_pc, dec_pcplus8,
        output imem_ready, imem_rvalid, imem_rdata, branch_en, branch_target, dec_ready
    );
endinterface

// File: rtl/fetch_unit.sv
// Single-outstanding instruction fetch unit with a one-entry decode buffer and
// branch redirect; responses to requests overtaken by a branch are discarded.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic         clk,
    input  logic         reset,
    fetch_unit_if.master bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } state_t;

    state_t      state;
    logic [31:0] pc;
    logic        kill;
    logic        dvalid;
    logic [31:0] dinstr;
    logic [31:0] dpc;

    logic        handoff;
    logic        req;
    logic        accept;
    logic [31:0] branch_pc;

    // A request may only leave when the buffer will be free at the next edge.
    assign handoff   = dvalid && bus.dec_ready;
    assign req       = (state == REQ) && (!dvalid || bus.dec_ready);
    assign accept    = req && bus.imem_ready;
    assign branch_pc = bus.branch_target & ~32'h0000_0003;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            pc     <= RESET_PC;
            kill   <= 1'b0;
            dvalid <= 1'b0;
            dinstr <= 32'h0;
            dpc    <= 32'h0;
        end else begin
            if (handoff) begin
                dvalid <= 1'b0;
            end

            case (state)
                IDLE: begin
                    state <= REQ;
                end
                REQ: begin
                    if (accept) begin
                        state <= WAIT;
                        if (bus.branch_en) begin
                            kill <= 1'b1;
                        end
                    end
                end
                WAIT: begin
                    if (bus.imem_rvalid) begin
                        state <= REQ;
                        kill  <= 1'b0;
                        if (!kill && !bus.branch_en) begin
                            dinstr <= bus.imem_rdata;
                            dpc    <= pc;
                            dvalid <= 1'b1;
                            pc     <= pc + 32'd4;
                        end
                    end else if (bus.branch_en) begin
                        kill <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase

            // Redirect has the last word over increment and buffer load.
            if (bus.branch_en) begin
                pc     <= branch_pc;
                dvalid <= 1'b0;
            end
        end
    end

    assign bus.imem_req    = req;
    assign bus.imem_addr   = pc;
    assign bus.dec_valid   = dvalid;
    assign bus.dec_instr   = dinstr;
    assign bus.dec_pc      = dpc;
    assign bus.dec_pcplus8 = dpc + 32'd8;

endmodule
